// File: rtl/icache_if.sv
// Fetcher and memory-controller signals of the instruction cache, bundled as one port.
// Requests are accepted only while fetch_ready is high, and nothing is queued.
// instr_valid and mem_valid are one-cycle pulses, and mem_enable is a level.
interface icache_if;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_flush;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        mem_enable;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_instr;

  modport master (
    output fetch_valid, fetch_addr, fetch_flush, mem_valid, mem_instr,
    input  fetch_ready, instr_valid, instr, mem_enable, mem_addr
  );

  modport slave (
    input  fetch_valid, fetch_addr, fetch_flush, mem_valid, mem_instr,
    output fetch_ready, instr_valid, instr, mem_enable, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with one 32-bit word per line and a single outstanding miss.
// A flush during a miss still fills the line, but the fetcher never sees the word.
module icache #(
  parameter int INDEX_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  icache_if.slave    bus,
  output logic [1:0] o_dbg_state
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MISS    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]             r_state;
  logic [LINES-1:0]       r_valid;
  logic [TAG_W-1:0]       r_tag  [LINES];
  logic [31:0]            r_data [LINES];
  logic                   r_instr_valid;
  logic [31:0]            r_instr;
  logic                   r_mem_enable;
  logic [29:0]            r_mem_word;

  logic [INDEX_WIDTH-1:0] w_req_idx;
  logic [TAG_W-1:0]       w_req_tag;
  logic [INDEX_WIDTH-1:0] w_fill_idx;
  logic [TAG_W-1:0]       w_fill_tag;
  logic                   w_hit;
  logic                   w_accept;
  logic                   w_fill;
  logic                   w_unused;

  assign w_req_idx  = bus.fetch_addr[INDEX_WIDTH+1:2];
  assign w_req_tag  = bus.fetch_addr[31:INDEX_WIDTH+2];
  assign w_fill_idx = r_mem_word[INDEX_WIDTH-1:0];
  assign w_fill_tag = r_mem_word[29:INDEX_WIDTH];
  assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_accept   = (r_state == S_IDLE) && bus.fetch_valid && !bus.fetch_flush;
  assign w_fill     = ((r_state == S_MISS) || (r_state == S_DISCARD)) && bus.mem_valid;
  assign w_unused   = ^bus.fetch_addr[1:0];

  assign bus.fetch_ready = (r_state == S_IDLE);
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.mem_enable  = r_mem_enable;
  assign bus.mem_addr    = {r_mem_word, 2'b00};
  assign o_dbg_state     = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'd0;
      r_mem_enable  <= 1'b0;
      r_mem_word    <= 30'd0;
    end else if (rdy) begin
      r_instr_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_hit) begin
              r_instr_valid <= 1'b1;
              r_instr       <= r_data[w_req_idx];
            end else begin
              r_mem_enable <= 1'b1;
              r_mem_word   <= bus.fetch_addr[31:2];
              r_state      <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (bus.mem_valid) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_mem_enable        <= 1'b0;
            r_state             <= S_IDLE;
            // A flush arriving with the response still fills the line but drops the result.
            if (!bus.fetch_flush) begin
              r_instr_valid <= 1'b1;
              r_instr       <= bus.mem_instr;
            end
          end else if (bus.fetch_flush) begin
            r_state <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (bus.mem_valid) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_mem_enable        <= 1'b0;
            r_state             <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag and data carry no reset; the valid bits alone decide whether a line is used.
  always_ff @(posedge clk) begin
    if (!rst && rdy && w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.mem_instr;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed corner cases, then random fetches checked against
// an array model of a 16-line direct-mapped cache.
module tb_icache;
  logic       clk;
  logic       rst;
  logic       rdy;
  logic [1:0] dbg_state;

  icache_if bus ();

  icache #(.INDEX_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_data  [16];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advances one clock; outputs are stable when this returns, and inputs may be driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [31:0] addr, input logic [31:0] word);
    int idx;
    idx = int'((addr / 4) % 16);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = addr / 64;
    m_data[idx]  = word;
  endtask

  function automatic bit model_hit(input logic [31:0] addr);
    int idx;
    idx = int'((addr / 4) % 16);
    return m_valid[idx] && (m_tag[idx] == addr / 64);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    return m_data[int'((addr / 4) % 16)];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check_eq("rst_ready", 32'(bus.fetch_ready), 32'd1);
    check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_instr", bus.instr, 32'd0);
    check_eq("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    rst = 1'b0;
    model_clear();
  endtask

  // Presents one request. On a miss, it answers after `delay` cycles with `word`.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int delay);
    bit hit;
    hit = model_hit(addr);
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = addr;
    step();
    bus.fetch_valid = 1'b0;
    if (hit) begin
      exp_q.push_back(model_word(addr));
      check_eq("hit_mem_enable", 32'(bus.mem_enable), 32'd0);
    end else begin
      check_eq("miss_mem_enable", 32'(bus.mem_enable), 32'd1);
      check_eq("miss_mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
      check_eq("miss_no_instr", 32'(bus.instr_valid), 32'd0);
      check_eq("miss_not_ready", 32'(bus.fetch_ready), 32'd0);
      for (int i = 0; i < delay; i++) begin
        step();
        check_eq("wait_mem_enable", 32'(bus.mem_enable), 32'd1);
        check_eq("wait_no_instr", 32'(bus.instr_valid), 32'd0);
      end
      bus.mem_valid = 1'b1;
      bus.mem_instr = word;
      step();
      bus.mem_valid = 1'b0;
      model_fill(addr, word);
      exp_q.push_back(word);
      check_eq("fill_mem_enable", 32'(bus.mem_enable), 32'd0);
      check_eq("fill_ready", 32'(bus.fetch_ready), 32'd1);
    end
    check_eq("instr_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("instr", bus.instr, exp_q.pop_front());
    step();
    check_eq("instr_pulse", 32'(bus.instr_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    rdy = 1'b1;
    bus.fetch_valid = 1'b0;
    bus.fetch_addr  = 32'd0;
    bus.fetch_flush = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.mem_instr   = 32'd0;
    do_reset();

    // Basic miss, then a hit on the same word, then an eviction and a re-miss.
    do_fetch(32'h0000_1000, 32'h0000_0013, 2);
    do_fetch(32'h0000_1002, 32'h0, 0);
    check_eq("hit_after_fill", 32'(model_hit(32'h0000_1000)), 32'd1);
    do_fetch(32'h0000_1040, 32'h1111_2222, 1);
    do_fetch(32'h0000_1000, 32'h0000_0013, 0);

    // Flush two cycles into a miss: the line fills and the result is dropped.
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h0000_2000;
    step();
    bus.fetch_valid = 1'b0;
    step();
    bus.fetch_flush = 1'b1;
    step();
    bus.fetch_flush = 1'b0;
    check_eq("flush_mem_enable", 32'(bus.mem_enable), 32'd1);
    check_eq("flush_not_ready", 32'(bus.fetch_ready), 32'd0);
    bus.mem_valid = 1'b1;
    bus.mem_instr = 32'hDEAD_BEEF;
    step();
    bus.mem_valid = 1'b0;
    model_fill(32'h0000_2000, 32'hDEAD_BEEF);
    check_eq("discard_no_instr", 32'(bus.instr_valid), 32'd0);
    check_eq("discard_mem_enable", 32'(bus.mem_enable), 32'd0);
    check_eq("discard_ready", 32'(bus.fetch_ready), 32'd1);
    step();
    check_eq("discard_quiet", 32'(bus.instr_valid), 32'd0);
    do_fetch(32'h0000_2000, 32'h0, 0);

    // Flush and response in the same cycle.
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h0000_2404;
    step();
    bus.fetch_valid = 1'b0;
    bus.fetch_flush = 1'b1;
    bus.mem_valid   = 1'b1;
    bus.mem_instr   = 32'hCAFE_F00D;
    step();
    bus.fetch_flush = 1'b0;
    bus.mem_valid   = 1'b0;
    model_fill(32'h0000_2404, 32'hCAFE_F00D);
    check_eq("flushfill_no_instr", 32'(bus.instr_valid), 32'd0);
    check_eq("flushfill_ready", 32'(bus.fetch_ready), 32'd1);
    check_eq("flushfill_mem_enable", 32'(bus.mem_enable), 32'd0);
    do_fetch(32'h0000_2404, 32'h0, 0);

    // Flush in IDLE cancels the request, and a stray mem_valid in IDLE is ignored.
    bus.fetch_valid = 1'b1;
    bus.fetch_flush = 1'b1;
    bus.fetch_addr  = 32'h0000_5000;
    step();
    bus.fetch_valid = 1'b0;
    bus.fetch_flush = 1'b0;
    check_eq("idle_flush_no_instr", 32'(bus.instr_valid), 32'd0);
    check_eq("idle_flush_no_mem", 32'(bus.mem_enable), 32'd0);
    bus.mem_valid = 1'b1;
    bus.mem_instr = 32'h5555_5555;
    step();
    bus.mem_valid = 1'b0;
    check_eq("stray_mem_no_instr", 32'(bus.instr_valid), 32'd0);
    do_fetch(32'h0000_5000, 32'h0BAD_0BAD, 1);

    // rdy low during a miss while mem_valid is held.
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h0000_6008;
    step();
    bus.fetch_valid = 1'b0;
    rdy = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_instr = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_mem_enable", 32'(bus.mem_enable), 32'd1);
      check_eq("stall_no_instr", 32'(bus.instr_valid), 32'd0);
      check_eq("stall_not_ready", 32'(bus.fetch_ready), 32'd0);
    end
    rdy = 1'b1;
    step();
    bus.mem_valid = 1'b0;
    model_fill(32'h0000_6008, 32'h1234_5678);
    check_eq("stall_instr_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("stall_instr", bus.instr, 32'h1234_5678);
    check_eq("stall_mem_drop", 32'(bus.mem_enable), 32'd0);
    step();
    check_eq("stall_once", 32'(bus.instr_valid), 32'd0);
    check_eq("stall_no_refetch", 32'(bus.mem_enable), 32'd0);
    do_fetch(32'h0000_6008, 32'h0, 0);

    // Reset in the middle of a miss abandons it, so the same address must miss again.
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h0000_3000;
    step();
    bus.fetch_valid = 1'b0;
    bus.mem_valid   = 1'b1;
    bus.mem_instr   = 32'h7777_7777;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.mem_valid = 1'b0;
    model_clear();
    check_eq("midrst_mem_enable", 32'(bus.mem_enable), 32'd0);
    check_eq("midrst_ready", 32'(bus.fetch_ready), 32'd1);
    check_eq("midrst_instr_valid", 32'(bus.instr_valid), 32'd0);
    do_fetch(32'h0000_3000, 32'h0000_0093, 1);
    do_fetch(32'h0000_1000, 32'h0000_0013, 0);

    // Random fetches over a small tag set, so that hits and evictions both occur.
    for (int n = 0; n < 80; n++) begin
      a = 32'h4000_0000 + 32'($urandom_range(0, 2)) * 64
        + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      do_fetch(a, $urandom, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_WIDTH, default 4, meaning log2 of line count (16 lines, one 32-bit word per line).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global enable; when 0, all state and outputs hold.
REQ-005 fetch_valid  input  1  fetcher requests instruction at fetch_addr.
REQ-006 fetch_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 fetch_flush  input  1  cancel pending request and suppress its result.
REQ-008 fetch_ready  output  1  high when cache is in IDLE and accepts a request.
REQ-009 instr_valid  output  1  one-cycle pulse; instr holds the requested word.
REQ-010 instr  output  32  returned instruction word.
REQ-011 mem_enable  output  1  miss request to memory controller; level, held until response.
REQ-012 mem_addr  output  32  word-aligned miss address ({fetch_addr[31:2],2'b00}).
REQ-013 mem_valid  input  1  one-cycle pulse from memory controller; mem_instr valid.
REQ-014 mem_instr  input  32  fetched word, little-endian assembled.

Function
REQ-015 Address split SHALL be index = addr[INDEX_WIDTH+1:2], tag = addr[31:INDEX_WIDTH+2].
REQ-016 Storage SHALL be per line: valid bit, tag, 32-bit data.
REQ-017 States SHALL be IDLE, MISS, DISCARD; fetch_ready = (state==IDLE), combinational.
REQ-018 IDLE, fetch_valid=1, fetch_flush=0, line valid and tag match: instr_valid=1 with line data on the next cycle (1-cycle hit latency); stay IDLE.
REQ-019 IDLE, fetch_valid=1, fetch_flush=0, miss: next cycle mem_enable=1, mem_addr=aligned address, request address latched; go MISS; instr_valid stays 0.
REQ-020 MISS, mem_valid=1: write line (valid=1, tag, mem_instr); next cycle instr_valid=1, instr=mem_instr, mem_enable=0; go IDLE.
REQ-021 mem_enable SHALL drop the cycle after mem_valid is sampled, so the controller never sees enable high on its return to IDLE (no duplicate fetch).
REQ-022 MISS, fetch_flush=1 (mem_valid=0): go DISCARD; mem_enable stays 1 until response.
REQ-023 DISCARD, mem_valid=1: write line as REQ-020, instr_valid stays 0, mem_enable drops; go IDLE.
REQ-024 MISS, fetch_flush=1 and mem_valid=1 same cycle: line written, no instr_valid, go IDLE.
REQ-025 IDLE, fetch_flush=1: request ignored regardless of fetch_valid; instr_valid=0 next cycle.
REQ-026 Requests while fetch_ready=0 SHALL be ignored; fetcher must re-present.
REQ-027 mem_valid outside MISS/DISCARD SHALL be ignored.
REQ-028 Line replacement SHALL be direct-mapped overwrite; same-index different-tag evicts.
REQ-029 instr_valid SHALL be high for exactly one cycle per served request.

Reset
REQ-030 rst=1 SHALL clear all valid bits, state=IDLE, instr_valid=0, instr=0, mem_enable=0, mem_addr=0, regardless of rdy.
REQ-031 rst mid-MISS/DISCARD SHALL abandon the miss with no line write; rst has priority over rdy and mem_valid.

Verification
REQ-032 Reset, request 0x0000_1000 -> mem_enable=1, mem_addr=0x1000; mem_valid with 0x0000_0013 -> next cycle instr_valid=1, instr=0x13, mem_enable=0.
REQ-033 Repeat request 0x1002 after REQ-032 -> hit: instr_valid=1 one cycle later, instr=0x13, mem_enable stays 0.
REQ-034 Request 0x1040 (same index, new tag) -> miss, mem_addr=0x1040; then 0x1000 -> miss again (evicted).
REQ-035 Miss on 0x2000, fetch_flush two cycles later, mem_valid with 0xDEADBEEF -> no instr_valid; subsequent 0x2000 hits with 0xDEADBEEF.
REQ-036 rdy=0 during MISS for 5 cycles with mem_valid pulse held -> no state change; on rdy=1 response processed once.
REQ-037 rst during MISS, then request same address -> fresh miss issued, no stale hit.
